// File: rtl/opb_coeff_pkg.sv
// Shared definitions for the OPB coefficient loader.
//   - Register byte offsets inside the slave window
//   - CTRL and STATUS bit positions
//   - Slave handshake FSM state encoding
//   - Saturating increment helper for the STATUS write counter
package opb_coeff_pkg;

    // Register byte offsets from C_BASEADDR
    localparam int unsigned OffCtrl   = 32'h0;
    localparam int unsigned OffPtr    = 32'h4;
    localparam int unsigned OffData   = 32'h8;
    localparam int unsigned OffStatus = 32'hC;

    // CTRL bits
    localparam int unsigned CtrlClearBit  = 0;
    localparam int unsigned CtrlCommitBit = 1;

    // STATUS fields
    localparam int unsigned StatCountWidth = 16;
    localparam int unsigned StatActiveBit  = 16;
    localparam int unsigned StatWrapBit    = 17;
    localparam int unsigned StatBeerrBit   = 18;

    typedef enum logic {
        SlvIdle = 1'b0,
        SlvAck  = 1'b1
    } slv_state_e;

    function automatic logic [StatCountWidth-1:0] sat_inc(input logic [StatCountWidth-1:0] v);
        return (&v) ? v : v + StatCountWidth'(1);
    endfunction

endpackage

// File: rtl/opb_slave_if.sv
// OPB slave handshake: accepts one transfer per hit, acknowledges it one cycle later and
// drives read data only during the acknowledge of a read.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   hit             - decoded select inside the slave window
//   rnw, offset,    - transfer attributes, captured when the hit is accepted
//   wdata, be
//   rdata           - read data for the captured offset (from the register file)
//   xferAck         - transfer acknowledge (one cycle)
//   DBus            - slave read data, zero outside a read acknowledge
//   ack_rnw, ack_offset, ack_wdata, ack_be - captured attributes, valid with xferAck
module opb_slave_if
    import opb_coeff_pkg::*;
#(
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hit,
    input  logic                      rnw,
    input  logic [C_OPB_AWIDTH-1:0]   offset,
    input  logic [C_OPB_DWIDTH-1:0]   wdata,
    input  logic [C_OPB_DWIDTH/8-1:0] be,
    input  logic [C_OPB_DWIDTH-1:0]   rdata,
    output logic                      xferAck,
    output logic [C_OPB_DWIDTH-1:0]   DBus,
    output logic                      ack_rnw,
    output logic [C_OPB_AWIDTH-1:0]   ack_offset,
    output logic [C_OPB_DWIDTH-1:0]   ack_wdata,
    output logic [C_OPB_DWIDTH/8-1:0] ack_be
);

    slv_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SlvIdle: if (hit) state_d = SlvAck;
            SlvAck:  state_d = SlvIdle;
            default: state_d = SlvIdle;
        endcase
    end

    // Reset masks the acknowledge in the same cycle so an aborted transfer has no effect.
    always_comb begin
        xferAck = (state_q == SlvAck) && !rst;
        DBus    = (xferAck && ack_rnw) ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SlvIdle;
            ack_rnw    <= 1'b0;
            ack_offset <= '0;
            ack_wdata  <= '0;
            ack_be     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SlvIdle && hit) begin
                ack_rnw    <= rnw;
                ack_offset <= offset;
                ack_wdata  <= wdata;
                ack_be     <= be;
            end
        end
    end

endmodule

// File: rtl/opb_coeff_loader.sv
// OPB slave that loads filter coefficients into a shadow bank and commits banks.
// Ports:
//   OPB_Clk, OPB_Rst         - clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/... - OPB master side (bit 0 is the MSB); OPB_seqAddr ignored
//   Sl_DBus, Sl_xferAck      - slave read data / acknowledge
//   Sl_errAck/retry/toutSup  - tied low
//   coeff_addr/data/we       - write port into the shadow coefficient bank
//   coeff_bank, active_bank  - bank being loaded / bank the filter reads
//   load_done                - one-cycle pulse on commit
module opb_coeff_loader
    import opb_coeff_pkg::*;
#(
    parameter int unsigned                C_OPB_AWIDTH  = 32,
    parameter int unsigned                C_OPB_DWIDTH  = 32,
    parameter logic [C_OPB_AWIDTH-1:0]    C_BASEADDR    = 32'h01000E00,
    parameter logic [C_OPB_AWIDTH-1:0]    C_HIGHADDR    = 32'h01000EFF,
    parameter int unsigned                C_COEFF_DEPTH = 256,
    parameter int unsigned                C_COEFF_WIDTH = 18,
    localparam int unsigned               PtrWidth      = $clog2(C_COEFF_DEPTH)
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]     OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
    input  logic                          OPB_RNW,
    input  logic                          OPB_select,
    input  logic                          OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
    output logic                          Sl_xferAck,
    output logic                          Sl_errAck,
    output logic                          Sl_retry,
    output logic                          Sl_toutSup,
    output logic [PtrWidth-1:0]           coeff_addr,
    output logic [C_COEFF_WIDTH-1:0]      coeff_data,
    output logic                          coeff_we,
    output logic                          coeff_bank,
    output logic                          active_bank,
    output logic                          load_done
);

    logic                      hit;
    logic [C_OPB_AWIDTH-1:0]   offset;
    logic                      ack;
    logic                      ack_rnw;
    logic [C_OPB_AWIDTH-1:0]   ack_offset;
    logic [C_OPB_DWIDTH-1:0]   ack_wdata;
    logic [C_OPB_DWIDTH/8-1:0] ack_be;
    logic [C_OPB_DWIDTH-1:0]   rdata;
    logic [C_OPB_DWIDTH-1:0]   dbus;

    assign hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign offset = OPB_ABus - C_BASEADDR;

    opb_slave_if #(
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH)
    ) u_slave_if (
        .clk        (OPB_Clk),
        .rst        (OPB_Rst),
        .hit        (hit),
        .rnw        (OPB_RNW),
        .offset     (offset),
        .wdata      (OPB_DBus),
        .be         (OPB_BE),
        .rdata      (rdata),
        .xferAck    (ack),
        .DBus       (dbus),
        .ack_rnw    (ack_rnw),
        .ack_offset (ack_offset),
        .ack_wdata  (ack_wdata),
        .ack_be     (ack_be)
    );

    // Plain vector assignment maps the LSB onto Sl_DBus[C_OPB_DWIDTH-1].
    assign Sl_DBus    = dbus;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_inputs;
    assign unused_inputs = OPB_seqAddr ^ (^ack_wdata);

    // Loader state
    logic [PtrWidth-1:0]       ptr_q, ptr_d;
    logic [StatCountWidth-1:0] count_q, count_d;
    logic                      wrap_q, wrap_d;
    logic                      beerr_q, beerr_d;
    logic                      active_q, active_d;
    logic [PtrWidth-1:0]       addr_q, addr_d;
    logic [C_COEFF_WIDTH-1:0]  data_q, data_d;

    logic sel_ctrl, sel_ptr, sel_data, sel_status;
    logic wr_ack, data_strobe, be_error, do_clear, do_commit, ptr_write;

    always_comb begin
        sel_ctrl    = (ack_offset == C_OPB_AWIDTH'(OffCtrl));
        sel_ptr     = (ack_offset == C_OPB_AWIDTH'(OffPtr));
        sel_data    = (ack_offset == C_OPB_AWIDTH'(OffData));
        sel_status  = (ack_offset == C_OPB_AWIDTH'(OffStatus));
        wr_ack      = ack && !ack_rnw;
        data_strobe = wr_ack && sel_data && (&ack_be);
        be_error    = wr_ack && sel_data && !(&ack_be);
        ptr_write   = wr_ack && sel_ptr;
        do_clear    = wr_ack && sel_ctrl && ack_wdata[CtrlClearBit];
        do_commit   = wr_ack && sel_ctrl && ack_wdata[CtrlCommitBit];
    end

    always_comb begin
        ptr_d    = ptr_q;
        count_d  = count_q;
        wrap_d   = wrap_q;
        beerr_d  = beerr_q;
        active_d = active_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (data_strobe) begin
            addr_d  = ptr_q;
            data_d  = ack_wdata[C_COEFF_WIDTH-1:0];
            // Depth is a power of two, so the natural overflow is the wrap to 0.
            ptr_d   = ptr_q + PtrWidth'(1);
            count_d = sat_inc(count_q);
            if (&ptr_q) wrap_d = 1'b1;
        end
        if (be_error)  beerr_d = 1'b1;
        if (ptr_write) ptr_d = ack_wdata[PtrWidth-1:0];
        // Clear is applied before commit when both bits are set.
        if (do_clear) begin
            ptr_d   = '0;
            count_d = '0;
            wrap_d  = 1'b0;
            beerr_d = 1'b0;
        end
        if (do_commit) begin
            active_d = !active_q;
            ptr_d    = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ptr_q    <= '0;
            count_q  <= '0;
            wrap_q   <= 1'b0;
            beerr_q  <= 1'b0;
            active_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            beerr_q  <= beerr_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Write port shows the live strobe values during ACK and holds the last write otherwise.
    always_comb begin
        coeff_we    = data_strobe;
        coeff_addr  = data_strobe ? ptr_q : addr_q;
        coeff_data  = data_strobe ? ack_wdata[C_COEFF_WIDTH-1:0] : data_q;
        load_done   = do_commit;
        active_bank = active_q;
        coeff_bank  = !active_q;
    end

    // Read mux; CTRL and unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        if (sel_ptr) begin
            rdata[PtrWidth-1:0] = ptr_q;
        end else if (sel_data) begin
            rdata[C_COEFF_WIDTH-1:0] = data_q;
        end else if (sel_status) begin
            rdata[StatCountWidth-1:0] = count_q;
            rdata[StatActiveBit]      = active_q;
            rdata[StatWrapBit]        = wrap_q;
            rdata[StatBeerrBit]       = beerr_q;
        end
    end

endmodule
